// File: rtl/counter_sequencer_4bit.sv
// Command-driven sequencer for a WIDTH-bit up/down counter with a prescaled step rate.
// Optional macro COUNTER_SEQ_AUTORELOAD_EN: stay in RUN and reload the count after each target hit.
module counter_sequencer_4bit #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0]       OP_STOP  = 2'b00;
    localparam logic [1:0]       OP_LOAD  = 2'b01;
    localparam logic [1:0]       OP_UP    = 2'b10;
    localparam logic [1:0]       OP_DOWN  = 2'b11;
    localparam logic [7:0]       PRE_LAST = 8'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [7:0]       prescaler_q, prescaler_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cmd_err_q, cmd_err_d;
    logic             accept_s;
    logic             tick_s;
    logic [WIDTH-1:0] next_val_s;

    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c, input logic up);
        return up ? (c + ONE) : (c - ONE);
    endfunction

    assign cmd_ready = (state_q != ST_DONE);
    assign accept_s  = cmd_valid && cmd_ready;
    assign tick_s    = (prescaler_q == PRE_LAST);

    // Value the count takes on the next tick; a count sitting on target reloads in periodic mode.
`ifdef COUNTER_SEQ_AUTORELOAD_EN
    assign next_val_s = (count_q == target_q) ? reload_q : step_count(count_q, dir_q);
`else
    assign next_val_s = step_count(count_q, dir_q);
`endif

    // Next-state and next-output decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        target_d    = target_q;
        reload_d    = reload_q;
        prescaler_d = prescaler_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            count_d  = cmd_data;
                            reload_d = cmd_data;
                        end
                        OP_UP, OP_DOWN: begin
                            target_d    = cmd_data;
                            dir_d       = ~cmd_op[0];
                            prescaler_d = 8'd0;
                            if (cmd_data == count_q) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // STOP beats a simultaneous tick, so the pending step is simply discarded.
                if (accept_s && (cmd_op == OP_STOP)) begin
                    state_d     = ST_IDLE;
                    prescaler_d = 8'd0;
                end else begin
                    cmd_err_d = accept_s;
                    if (tick_s) begin
                        prescaler_d = 8'd0;
                        count_d     = next_val_s;
                        if (next_val_s == target_q) begin
                            done_d = 1'b1;
`ifndef COUNTER_SEQ_AUTORELOAD_EN
                            state_d = ST_DONE;
`endif
                        end else begin
                            done_d = 1'b0;
                        end
                    end else begin
                        prescaler_d = prescaler_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= {WIDTH{1'b0}};
            target_q    <= {WIDTH{1'b0}};
            reload_q    <= {WIDTH{1'b0}};
            prescaler_q <= 8'd0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            target_q    <= target_d;
            reload_q    <= reload_d;
            prescaler_q <= prescaler_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign count   = count_q;
    assign dir     = dir_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: doc/counter_sequencer_4bit.md
Name: counter_sequencer_4bit

Overview:
Command-driven controller that sequences a 4-bit synchronous up/down binary counter.
- Accepts LOAD / RUN_UP / RUN_DOWN / STOP commands over a valid/ready handshake.
- Steps the count at a prescaled rate until a programmed target is reached, then pulses done.
- Sits between a host/register interface and the counter datapath; it owns the count state, direction and terminal detection.

Parameters:
WIDTH, 4, count/target/load width; count wraps modulo 2^WIDTH
PRESCALE, 1, clocks per count step while running; legal range 1..255

Ports:
clock  input  1  single rising-edge clock
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted this cycle
cmd_op  input  2  00 STOP, 01 LOAD, 10 RUN_UP, 11 RUN_DOWN
cmd_data  input  WIDTH  LOAD: new count value; RUN_*: target value
count  output  WIDTH  current count (registered)
dir  output  1  1 = up, 0 = down; last RUN direction
busy  output  1  1 while state is RUN
done  output  1  one-cycle pulse when target is reached
cmd_err  output  1  one-cycle pulse when a command is dropped

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, reset_n). Reset asserts immediately, deasserts synchronously to the design.
- Reset values: count=0, dir=0, busy=0, done=0, cmd_err=0, target=0, reload_reg=0, prescaler=0, state IDLE.
- All outputs are registered; cmd_ready is decoded from state.
- Handshake: a command is accepted when cmd_valid && cmd_ready at a rising edge. cmd_ready=1 in IDLE and RUN, 0 in DONE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - LOAD: count<=cmd_data and reload_reg<=cmd_data; stay IDLE.
  - RUN_UP / RUN_DOWN: target<=cmd_data; dir<=1 or 0; prescaler<=0; go RUN.
  - RUN_* with cmd_data==count: go DONE directly; count unchanged.
  - STOP: no-op; no error.
- RUN:
  - busy=1. prescaler counts 0..PRESCALE-1; tick when prescaler==PRESCALE-1, then prescaler returns to 0.
  - On tick: count<=count+1 (dir=1) or count-1 (dir=0), modulo 2^WIDTH (15->0 up, 0->15 down).
  - If the updated count equals target, go DONE on the same edge.
- DONE: done=1 for exactly this one cycle, busy=0, cmd_ready=0; next state IDLE.
- STOP in RUN: go IDLE; count holds; no done pulse.
- STOP in the same cycle as a terminal tick: STOP wins; the tick is discarded, count stays at its pre-tick value, no done.
- LOAD or RUN_* accepted in RUN: dropped, cmd_err pulses one cycle, run continues unaffected.
- Latency, PRESCALE=1: RUN accepted at edge 0; count changes at edges 1,2,...; done is high in the cycle after the edge on which count reaches target.
- Reset mid-run: immediate return to all reset values; the pending done is lost.

Optional Feature:
Macro COUNTER_SEQ_AUTORELOAD_EN.
- Defined: reaching target does not enter DONE. The FSM stays in RUN, done pulses one cycle, and on the next tick count<=reload_reg instead of stepping. This gives a periodic sequence; only STOP or reset returns to IDLE. busy stays 1 throughout.
- Undefined: RUN -> DONE -> IDLE one-shot behaviour as above; reload_reg is still written by LOAD but unused.

Test Plan:
- Reset: assert reset_n=0 mid-run with count=7 -> count=0, busy=0, done=0, cmd_ready=1 immediately, without waiting for a clock edge.
- LOAD 3, then RUN_UP 5, PRESCALE=1 -> count 3,4,5 on successive edges; done high one cycle after count=5; IDLE next; cmd_ready low only during the DONE cycle.
- LOAD 1, RUN_DOWN 14 -> count 1,0,15,14; dir=0; single done pulse; no further change.
- PRESCALE=3, LOAD 0, RUN_UP 2 -> count changes every 3rd clock (0 to 1 at edge 3, 1 to 2 at edge 6); done in the cycle after edge 6.
- RUN_UP 9 from count 4; STOP presented on the cycle of the 8->9 tick -> count stays 8, IDLE, no done. Separately, RUN_UP 4 with count=4 -> done next cycle, count unchanged.
- LOAD 6 issued during RUN -> cmd_err one-cycle pulse, count sequence unchanged. With COUNTER_SEQ_AUTORELOAD_EN, LOAD 2, RUN_UP 4 -> sequence 2,3,4,2,3,4,..., done pulse on each arrival at 4.
